// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: safety monitor placed between the intersection
// controller and the lamp drivers. It checks encoding, cross-road conflicts,
// transition order and phase timing every clock, and mirrors the controller
// onto the lamps one cycle later. On the first violation it latches a cause
// code and flashes both roads red until an operator clear with all-red inputs.
// Optional build macro TL_MON_PHASE_COUNT_EN adds the phase_cnt output, which
// counts legal road-A green-to-yellow transitions.
module traffic_light_monitor #(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_STUCK  = 60,
    parameter int FLASH_DIV  = 1,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  light_A,
    input  logic [2:0]  light_B,
    input  logic        clr,
    output logic [2:0]  safe_A,
    output logic [2:0]  safe_B,
    output logic        fault,
    output logic [2:0]  fault_code
`ifdef TL_MON_PHASE_COUNT_EN
    ,
    output logic [15:0] phase_cnt
`endif
);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam int         FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FAULT  = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [2:0]          safe_a_reg, safe_a_next;
    logic [2:0]          safe_b_reg, safe_b_next;
    logic                fault_reg, fault_next;
    logic [2:0]          code_reg, code_next;
    logic                flash_phase_reg, flash_phase_next;
    logic [FLASH_W-1:0]  flash_cnt_reg, flash_cnt_next;
    logic [2:0]          prev_reg [2];
    logic [2:0]          prev_next [2];
    logic [CNT_W-1:0]    dwell_reg [2];
    logic [CNT_W-1:0]    dwell_next [2];
`ifdef TL_MON_PHASE_COUNT_EN
    logic [15:0]         phase_cnt_reg, phase_cnt_next;
`endif

    // Per-road view of the sampled inputs and the per-road check results
    logic [2:0]          light [2];
    logic [1:0]          onehot;
    logic [1:0]          nonred;
    logic [1:0]          changed;
    logic [1:0]          legal_step;
    logic [1:0]          illegal;
    logic [1:0]          short_yellow;
    logic [1:0]          stuck;
    logic [CNT_W-1:0]    dwell_track [2];
    logic                conflict;
    logic [2:0]          viol_code;
    logic                a_green_to_yellow;

    assign light[0] = light_A;
    assign light[1] = light_B;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_road
            assign onehot[gi]  = (light[gi] == GREEN) || (light[gi] == YELLOW) ||
                                 (light[gi] == RED);
            assign nonred[gi]  = |light[gi][1:0];
            assign changed[gi] = (light[gi] != prev_reg[gi]);
            assign legal_step[gi] = ((prev_reg[gi] == GREEN)  && (light[gi] == YELLOW)) ||
                                    ((prev_reg[gi] == YELLOW) && (light[gi] == RED))    ||
                                    ((prev_reg[gi] == RED)    && (light[gi] == GREEN));
            // An invalid code is reported as an encoding error instead
            assign illegal[gi] = onehot[gi] && changed[gi] && !legal_step[gi];
            // Yellow dwell before this sample is the length of the yellow phase
            assign short_yellow[gi] = (prev_reg[gi] == YELLOW) && (light[gi] == RED) &&
                                      (dwell_reg[gi] < CNT_W'(MIN_YELLOW));
            // Dwell including the current sample, saturating at the counter maximum
            assign dwell_track[gi] = changed[gi] ? CNT_W'(1) :
                                     (dwell_reg[gi] == DWELL_MAX) ? dwell_reg[gi] :
                                     dwell_reg[gi] + CNT_W'(1);
            assign stuck[gi] = (dwell_track[gi] >= CNT_W'(MAX_STUCK));
        end
    endgenerate

    assign conflict          = nonred[0] && nonred[1];
    assign a_green_to_yellow = (prev_reg[0] == GREEN) && (light_A == YELLOW);

    // Lowest code wins when several violations coincide
    always_comb begin
        viol_code = 3'd0;
        if (conflict)
            viol_code = 3'd1;
        else if (!(&onehot))
            viol_code = 3'd2;
        else if (|illegal)
            viol_code = 3'd3;
        else if (|short_yellow)
            viol_code = 3'd4;
        else if (|stuck)
            viol_code = 3'd5;
    end

    // Next-state and output logic of the NORMAL/FAULT machine
    always_comb begin
        state_next       = state_reg;
        safe_a_next      = safe_a_reg;
        safe_b_next      = safe_b_reg;
        fault_next       = fault_reg;
        code_next        = code_reg;
        flash_phase_next = flash_phase_reg;
        flash_cnt_next   = flash_cnt_reg;
        prev_next[0]     = light_A;
        prev_next[1]     = light_B;
        dwell_next[0]    = dwell_track[0];
        dwell_next[1]    = dwell_track[1];
`ifdef TL_MON_PHASE_COUNT_EN
        phase_cnt_next   = phase_cnt_reg;
`endif
        case (state_reg)
            NORMAL: begin
                if (viol_code != 3'd0) begin
                    state_next       = FAULT;
                    fault_next       = 1'b1;
                    code_next        = viol_code;
                    safe_a_next      = RED;
                    safe_b_next      = RED;
                    flash_phase_next = 1'b1;
                    flash_cnt_next   = '0;
                end else begin
                    safe_a_next = light_A;
                    safe_b_next = light_B;
`ifdef TL_MON_PHASE_COUNT_EN
                    if (a_green_to_yellow)
                        phase_cnt_next = phase_cnt_reg + 16'd1;
`endif
                end
            end
            FAULT: begin
                if (clr && (light_A == RED) && (light_B == RED)) begin
                    state_next       = NORMAL;
                    fault_next       = 1'b0;
                    code_next        = 3'd0;
                    safe_a_next      = RED;
                    safe_b_next      = RED;
                    prev_next[0]     = RED;
                    prev_next[1]     = RED;
                    dwell_next[0]    = CNT_W'(1);
                    dwell_next[1]    = CNT_W'(1);
                    flash_phase_next = 1'b1;
                    flash_cnt_next   = '0;
                end else begin
                    // Half-period of FLASH_DIV cycles, both roads in step
                    if (flash_cnt_reg == FLASH_W'(FLASH_DIV - 1)) begin
                        flash_cnt_next   = '0;
                        flash_phase_next = ~flash_phase_reg;
                    end else begin
                        flash_cnt_next   = flash_cnt_reg + FLASH_W'(1);
                    end
                    safe_a_next = {flash_phase_next, 2'b00};
                    safe_b_next = {flash_phase_next, 2'b00};
                end
            end
            default: begin
                state_next = NORMAL;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= NORMAL;
            safe_a_reg      <= RED;
            safe_b_reg      <= RED;
            fault_reg       <= 1'b0;
            code_reg        <= 3'd0;
            flash_phase_reg <= 1'b1;
            flash_cnt_reg   <= '0;
            prev_reg[0]     <= RED;
            prev_reg[1]     <= RED;
            dwell_reg[0]    <= '0;
            dwell_reg[1]    <= '0;
`ifdef TL_MON_PHASE_COUNT_EN
            phase_cnt_reg   <= 16'd0;
`endif
        end else begin
            state_reg       <= state_next;
            safe_a_reg      <= safe_a_next;
            safe_b_reg      <= safe_b_next;
            fault_reg       <= fault_next;
            code_reg        <= code_next;
            flash_phase_reg <= flash_phase_next;
            flash_cnt_reg   <= flash_cnt_next;
            prev_reg[0]     <= prev_next[0];
            prev_reg[1]     <= prev_next[1];
            dwell_reg[0]    <= dwell_next[0];
            dwell_reg[1]    <= dwell_next[1];
`ifdef TL_MON_PHASE_COUNT_EN
            phase_cnt_reg   <= phase_cnt_next;
`endif
        end
    end

    assign safe_A     = safe_a_reg;
    assign safe_B     = safe_b_reg;
    assign fault      = fault_reg;
    assign fault_code = code_reg;
`ifdef TL_MON_PHASE_COUNT_EN
    assign phase_cnt  = phase_cnt_reg;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: a table of directed single-cycle
// vectors followed by hand-written multi-cycle sequences (legal cycle,
// short yellow, stuck colour). One line is printed per applied cycle.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [2:0]  light_A = R;
    logic [2:0]  light_B = R;
    logic [2:0]  safe_A;
    logic [2:0]  safe_B;
    logic        fault;
    logic [2:0]  fault_code;
`ifdef TL_MON_PHASE_COUNT_EN
    logic [15:0] phase_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    traffic_light_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .light_A    (light_A),
        .light_B    (light_B),
        .clr        (clr),
        .safe_A     (safe_A),
        .safe_B     (safe_B),
        .fault      (fault),
        .fault_code (fault_code)
`ifdef TL_MON_PHASE_COUNT_EN
        ,
        .phase_cnt  (phase_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       c;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] sa;
        logic [2:0] sb;
        logic       f;
        logic [2:0] code;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic r, input logic c, input logic [2:0] a, input logic [2:0] b);
        rst     = r;
        clr     = c;
        light_A = a;
        light_B = b;
        @(posedge clk);
        #1;
        cycle++;
        $display("cyc %0d rst=%0b clr=%0b A=%03b B=%03b -> safe_A=%03b safe_B=%03b fault=%0b code=%0d",
                 cycle, r, c, a, b, safe_A, safe_B, fault, fault_code);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, R, R);
        step(1'b1, 1'b0, R, R);
    endtask

    initial begin
        //           rst   clr   A       B       safe_A  safe_B  fault code
        vecs[0]  = '{1'b1, 1'b0, 3'b001, 3'b010, R,      R,      1'b0, 3'd0};
        vecs[1]  = '{1'b1, 1'b0, 3'b111, 3'b000, R,      R,      1'b0, 3'd0};
        vecs[2]  = '{1'b0, 1'b0, R,      R,      R,      R,      1'b0, 3'd0};
        vecs[3]  = '{1'b0, 1'b0, G,      R,      G,      R,      1'b0, 3'd0};
        vecs[4]  = '{1'b0, 1'b0, G,      Y,      R,      R,      1'b1, 3'd1};
        vecs[5]  = '{1'b0, 1'b0, G,      Y,      3'b000, 3'b000, 1'b1, 3'd1};
        vecs[6]  = '{1'b0, 1'b0, 3'b000, 3'b000, R,      R,      1'b1, 3'd1};
        vecs[7]  = '{1'b0, 1'b1, G,      R,      3'b000, 3'b000, 1'b1, 3'd1};
        vecs[8]  = '{1'b0, 1'b1, R,      R,      R,      R,      1'b0, 3'd0};
        vecs[9]  = '{1'b0, 1'b0, R,      R,      R,      R,      1'b0, 3'd0};
        vecs[10] = '{1'b0, 1'b0, G,      3'b011, R,      R,      1'b1, 3'd1};
        vecs[11] = '{1'b0, 1'b0, 3'b000, R,      3'b000, 3'b000, 1'b1, 3'd1};
        vecs[12] = '{1'b0, 1'b0, R,      R,      R,      R,      1'b1, 3'd1};
        vecs[13] = '{1'b1, 1'b0, G,      Y,      R,      R,      1'b0, 3'd0};
        vecs[14] = '{1'b0, 1'b0, R,      R,      R,      R,      1'b0, 3'd0};
        vecs[15] = '{1'b0, 1'b1, R,      R,      R,      R,      1'b0, 3'd0};
        vecs[16] = '{1'b0, 1'b0, G,      R,      G,      R,      1'b0, 3'd0};
        vecs[17] = '{1'b0, 1'b0, R,      R,      R,      R,      1'b1, 3'd3};
        vecs[18] = '{1'b0, 1'b0, R,      R,      3'b000, 3'b000, 1'b1, 3'd3};
        vecs[19] = '{1'b1, 1'b0, R,      R,      R,      R,      1'b0, 3'd0};
        vecs[20] = '{1'b0, 1'b0, 3'b110, R,      R,      R,      1'b1, 3'd2};
        vecs[21] = '{1'b1, 1'b0, R,      R,      R,      R,      1'b0, 3'd0};
        vecs[22] = '{1'b0, 1'b0, R,      Y,      R,      R,      1'b1, 3'd3};
        vecs[23] = '{1'b1, 1'b0, R,      R,      R,      R,      1'b0, 3'd0};

        // Directed single-cycle vectors
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].r, vecs[i].c, vecs[i].a, vecs[i].b);
            check("vec_safe_A", 16'(safe_A), 16'(vecs[i].sa));
            check("vec_safe_B", 16'(safe_B), 16'(vecs[i].sb));
            check("vec_fault", 16'(fault), 16'(vecs[i].f));
            check("vec_code", 16'(fault_code), 16'(vecs[i].code));
`ifdef TL_MON_PHASE_COUNT_EN
            if (vecs[i].r)
                check("vec_phase_reset", phase_cnt, 16'd0);
`endif
        end

        // Legal full cycle: A G10 Y3 R, then B G10 Y3 R; outputs mirror inputs
        do_reset();
        for (int i = 0; i < 27; i++) begin
            logic [2:0] a;
            logic [2:0] b;
            if (i < 10)      begin a = G; b = R; end
            else if (i < 13) begin a = Y; b = R; end
            else if (i < 23) begin a = R; b = G; end
            else if (i < 26) begin a = R; b = Y; end
            else             begin a = R; b = R; end
            step(1'b0, 1'b0, a, b);
            check("legal_safe_A", 16'(safe_A), 16'(a));
            check("legal_safe_B", 16'(safe_B), 16'(b));
            check("legal_fault", 16'(fault), 16'd0);
`ifdef TL_MON_PHASE_COUNT_EN
            if (i == 9)  check("phase_before_gy", phase_cnt, 16'd0);
            if (i == 10) check("phase_after_gy", phase_cnt, 16'd1);
            if (i == 26) check("phase_end", phase_cnt, 16'd1);
`endif
        end

        // Short yellow on road A: two yellow samples then red
        do_reset();
        step(1'b0, 1'b0, G, R);
        step(1'b0, 1'b0, G, R);
        step(1'b0, 1'b0, Y, R);
        step(1'b0, 1'b0, Y, R);
        check("short_y_pre_fault", 16'(fault), 16'd0);
        step(1'b0, 1'b0, R, R);
        check("short_y_fault", 16'(fault), 16'd1);
        check("short_y_code", 16'(fault_code), 16'd4);
        check("short_y_safe_A", 16'(safe_A), 16'(R));
        // Clear with road A not red is refused
        step(1'b0, 1'b1, G, R);
        check("clr_refused_fault", 16'(fault), 16'd1);
        check("clr_refused_code", 16'(fault_code), 16'd4);

        // Road A held green: fault on exactly the 60th sample
        do_reset();
        for (int i = 1; i <= 60; i++) begin
            step(1'b0, 1'b0, G, R);
            if (i == 59) begin
                check("stuck_59_fault", 16'(fault), 16'd0);
                check("stuck_59_safe_A", 16'(safe_A), 16'(G));
            end
            if (i == 60) begin
                check("stuck_60_fault", 16'(fault), 16'd1);
                check("stuck_60_code", 16'(fault_code), 16'd5);
            end
        end
        // Later violations do not overwrite the first code
        step(1'b0, 1'b0, G, G);
        check("stuck_code_hold", 16'(fault_code), 16'd5);
        check("stuck_flash", 16'(safe_B), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
